pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage MIPS core. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and later pipeline registers, which makes it the sequencer for the ID/EX register's flush input. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, with a wait timeout. It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard control unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_MAX_WAIT = 16;
  localparam int DEF_PERF_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per enabled cycle and stick at the all-ones value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage MIPS core: load-use stalls, taken-branch
// flushes, data-memory waits with timeout, and stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int PERF_W   = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_hold,
  output logic              timeout_err,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  // wait_cnt reaches MAX_WAIT on the cycle that enters TIMEOUT, so size for that.
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  ctrl_state_e   state;
  ctrl_state_e   next_state;
  logic [CW-1:0] wait_cnt;
  logic          load_use;
  logic          mem_stall;
  logic          flush_evt;
  logic          stall_evt;

  assign load_use  = ex_memread && (ex_rt != REG_ZERO) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mem_stall = dmem_req && !dmem_ready;

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= next_state;
      timeout_err <= timeout_err || (next_state == TIMEOUT);
      if (state == RUN && mem_stall) begin
        wait_cnt <= CW'(1);
      end else if (state == MEM_WAIT && !dmem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else if (state == MEM_WAIT) begin
        wait_cnt <= '0;
      end
    end
  end

  // Next-state logic: enter wait on a memory stall, leave on ready or time out.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (mem_stall) next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_ready)                next_state = RUN;
        else if (wait_cnt == LAST_WAIT) next_state = TIMEOUT;
      end
      TIMEOUT: next_state = TIMEOUT;
      default: next_state = RUN;
    endcase
  end

  // Mealy control outputs: memory hold beats branch flush beats load-use stall.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    flush_evt  = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if ((state == TIMEOUT) ||
                 (state == RUN && mem_stall) ||
                 (state == MEM_WAIT && !dmem_ready)) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign stall_evt = !rst && !pc_write;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_evt),
    .count (stall_cycles)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_evt),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MAX_WAIT=4, PERF_W=4).
module tb_pipe_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int PERF_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_memread;
  logic [4:0]        ex_rt;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rt;
  logic              branch_taken;
  logic              dmem_req;
  logic              dmem_ready;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              pipe_hold;
  logic              timeout_err;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  int checks = 0;
  int passes = 0;

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .pipe_hold    (pipe_hold),
    .timeout_err  (timeout_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Control bundle order: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}.
  task automatic checkCtrl(input string tag, input logic [4:0] exp);
    checkOutput(tag, 32'({pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}), 32'(exp));
  endtask

  // Drive one cycle's inputs just after the falling edge and settle.
  task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] ert,
                               input logic [4:0] irs, input logic [4:0] irt, input logic urt,
                               input logic br, input logic req, input logic rdy);
    @(negedge clk);
    rst          = r;
    ex_memread   = mr;
    ex_rt        = ert;
    id_rs        = irs;
    id_rt        = irt;
    id_uses_rt   = urt;
    branch_taken = br;
    dmem_req     = req;
    dmem_ready   = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_memread = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtrl("reset_ctrl", 5'b00110);
    checkOutput("reset_stall", 32'(stall_cycles), 0);
    checkOutput("reset_flush", 32'(flush_count), 0);
    checkOutput("reset_terr", 32'(timeout_err), 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtrl("idle_ctrl", 5'b11000);

    applyStimulus(0, 1, 8, 8, 0, 0, 0, 0, 0);
    checkCtrl("lu_rs_ctrl", 5'b00010);
    applyStimulus(0, 0, 8, 8, 0, 0, 0, 0, 0);
    checkCtrl("lu_after_ctrl", 5'b11000);
    checkOutput("lu_stall", 32'(stall_cycles), 1);

    applyStimulus(0, 1, 9, 3, 9, 1, 0, 0, 0);
    checkCtrl("lu_rt_ctrl", 5'b00010);
    applyStimulus(0, 1, 9, 3, 9, 0, 0, 0, 0);
    checkCtrl("rt_unused_ctrl", 5'b11000);
    checkOutput("rt_stall", 32'(stall_cycles), 2);

    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0);
    checkCtrl("zero_reg_ctrl", 5'b11000);

    applyStimulus(0, 1, 8, 8, 0, 0, 1, 0, 0);
    checkCtrl("br_lu_ctrl", 5'b11110);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtrl("br_after_ctrl", 5'b11000);
    checkOutput("br_flush", 32'(flush_count), 1);
    checkOutput("br_stall", 32'(stall_cycles), 2);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkCtrl("wait1_ctrl", 5'b00001);
    applyStimulus(0, 1, 8, 8, 0, 0, 1, 1, 0);
    checkCtrl("wait2_ctrl", 5'b00001);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkCtrl("wait3_ctrl", 5'b00001);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkCtrl("wait_release_ctrl", 5'b11000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtrl("wait_after_ctrl", 5'b11000);
    checkOutput("wait_stall", 32'(stall_cycles), 5);
    checkOutput("wait_flush", 32'(flush_count), 1);
    checkOutput("wait_terr", 32'(timeout_err), 0);

    for (int i = 0; i < MAX_WAIT; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkCtrl("to_hold_ctrl", 5'b00001);
    end
    checkOutput("to_terr_pre", 32'(timeout_err), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkCtrl("to_ready_ctrl", 5'b00001);
    checkOutput("to_terr", 32'(timeout_err), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtrl("to_idle_ctrl", 5'b00001);
    checkOutput("to_terr_sticky", 32'(timeout_err), 1);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtrl("rst2_ctrl", 5'b00110);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtrl("rst2_run_ctrl", 5'b11000);
    checkOutput("rst2_terr", 32'(timeout_err), 0);
    checkOutput("rst2_stall", 32'(stall_cycles), 0);
    checkOutput("rst2_flush", 32'(flush_count), 0);

    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 1, 12, 7, 12, 1, 0, 0, 0);
      applyStimulus(0, 0, 12, 7, 12, 1, 0, 0, 0);
      if (i == 10) checkOutput("sat_10", 32'(stall_cycles), 10);
      if (i == 15) checkOutput("sat_15", 32'(stall_cycles), 15);
      if (i == 16) checkOutput("sat_16", 32'(stall_cycles), 15);
      if (i == 20) checkOutput("sat_20", 32'(stall_cycles), 15);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
